wb_mem: RTL

//   Parametrised Wishbone classic slave memory; generalises the fixed 1 kB boot ROM.

---
 rtl/wb_mem.sv | 135 +++++++++++++
 1 files changed

// File: rtl/wb_mem.sv
// Wishbone classic slave memory (ROM or byte-lane RAM) with configurable wait states.
// Response arrives 2+WAIT_STATES edges after stb is sampled; a dropped cyc/stb during WAIT aborts silently.
module wb_mem #(
  parameter int AW          = 32,
  parameter int DW          = 32,
  parameter int DEPTH       = 256,
  parameter int READ_ONLY   = 1,
  parameter int WAIT_STATES = 0
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_i,
  input  logic [DW-1:0]   wb_dat_i,
  output logic [DW-1:0]   wb_dat_o,
  input  logic [AW-1:0]   wb_adr_i,
  input  logic [DW/8-1:0] wb_sel_i,
  input  logic            wb_we_i,
  input  logic            wb_cyc_i,
  input  logic            wb_stb_i,
  output logic            wb_ack_o,
  output logic            wb_err_o
);

  localparam int OFF = $clog2(DW / 8);
  localparam int IXW = $clog2(DEPTH);
  localparam int FW  = AW - OFF;
  localparam logic [3:0] WS_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  state_e          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            rerr_q, rerr_d;
  logic            rwe_q, rwe_d;
  logic            ack_q, ack_d;
  logic            err_q, err_d;
  logic [DW-1:0]   dat_q, dat_d;
  logic            mem_wr;

  logic [DW-1:0]   mem [DEPTH];

  logic [FW-1:0]   word_idx;
  logic [IXW-1:0]  mem_idx;
  logic            in_range;
  logic            req;
  logic            reject;
  logic            addr_unused;

  assign word_idx    = wb_adr_i[AW-1:OFF];
  assign mem_idx     = word_idx[IXW-1:0];
  assign in_range    = (word_idx >> IXW) == '0;
  assign req         = wb_cyc_i & wb_stb_i;
  assign reject      = !in_range || (wb_we_i && (READ_ONLY != 0));
  assign addr_unused = ^wb_adr_i[OFF-1:0];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rerr_d  = rerr_q;
    rwe_d   = rwe_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    dat_d   = dat_q;
    mem_wr  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          cnt_d = WS_LOAD;
          if (WAIT_STATES == 0) begin
            state_d = RESP;
            rerr_d  = reject;
            rwe_d   = wb_we_i;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (!req) begin
          state_d = IDLE;
        end else if (cnt_q == 4'd0) begin
          state_d = RESP;
          rerr_d  = reject;
          rwe_d   = wb_we_i;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        // The ack/err edge is also the edge that commits the read or write.
        state_d = IDLE;
        ack_d   = !rerr_q;
        err_d   = rerr_q;
        if (!rerr_q) begin
          if (rwe_q) mem_wr = 1'b1;
          else       dat_d  = mem[mem_idx];
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      rerr_q  <= 1'b0;
      rwe_q   <= 1'b0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      dat_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rerr_q  <= rerr_d;
      rwe_q   <= rwe_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      dat_q   <= dat_d;
    end
  end

  // Contents survive reset; reset forces IDLE, so a pending write never commits.
  always_ff @(posedge wb_clk_i) begin
    if (mem_wr && (READ_ONLY == 0)) begin
      for (int i = 0; i < DW / 8; i++) begin
        if (wb_sel_i[i]) mem[mem_idx][8*i +: 8] <= wb_dat_i[8*i +: 8];
      end
    end
  end

  assign wb_ack_o = ack_q;
  assign wb_err_o = err_q;
  assign wb_dat_o = dat_q;

endmodule
